generic_dsp_param: RTL

Parametrised behavioural model of the DSP slice used by the FIOS Montgomery multiplier datapath, generalising the fixed 17-bit, non-cascaded DSP model. Supports configurable operand width, A/B pipeline depth (0–2), optional M and C registers, a synchronous reset, a global clock enable, and a valid tag carried alongside each operation. Sits wherever the FIOS PE instantiates a DSP, in simulation and in portable (non-Xilinx) builds.

---
 rtl/generic_dsp_param.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/generic_dsp_param.sv
// generic_dsp_param
// Behavioural model of the DSP slice used by the FIOS Montgomery datapath.
// Unsigned multiply, optional add/accumulate/shift through a 48-bit P register,
// with a valid tag that travels in step with each operation.
//
// Parameters: WIDTH (8..23), ABREG (0..2), MREG (0/1), CREG (0/1).
// Optional feature macro: GENERIC_DSP_SUB_EN enables P <= Z - XY when SUB_i
// is set at issue; without it SUB_i is ignored and P <= Z + XY always.
//
// Ports:
//   clock_i    rising-edge clock
//   reset_i    synchronous active-high reset, overrides CE_i
//   CE_i       global clock enable, 0 freezes every register
//   valid_i    issue tag, emerges on valid_o after LATENCY cycles
//   OPMODE_i   [3:0] XY select, [6:4] Z select, issued with A_i/B_i
//   SUB_i      subtract select, issued with OPMODE_i
//   CREG_en_i  load enable for the C register
//   A_i, B_i   unsigned operands
//   C_i        addend
//   P_o        P[2*WIDTH-1:0]
//   carry_o    P[2*WIDTH]
//   valid_o    delayed valid_i
module generic_dsp_param #(
   parameter int WIDTH = 17,
   parameter int ABREG = 1,
   parameter int MREG  = 1,
   parameter int CREG  = 1
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 CE_i,
   input  logic                 valid_i,
   input  logic [6:0]           OPMODE_i,
   input  logic                 SUB_i,
   input  logic                 CREG_en_i,
   input  logic [WIDTH-1:0]     A_i,
   input  logic [WIDTH-1:0]     B_i,
   input  logic [2*WIDTH-1:0]   C_i,
   output logic [2*WIDTH-1:0]   P_o,
   output logic                 carry_o,
   output logic                 valid_o
);

   localparam int LATENCY = ABREG + MREG + 1;
   // control tag must arrive at the P stage together with its own product
   localparam int CTL_D   = LATENCY - 1;

   logic [WIDTH-1:0]   a_ab, b_ab;
   logic [WIDTH-1:0]   a_p, b_p;
   logic [2*WIDTH-1:0] prod, m_p, c_p;
   logic               sub_in;
   logic [8:0]         ctl_in, ctl_p;
   logic [47:0]        xy, z, p_d, p_q;
   logic               valid_q;

`ifdef GENERIC_DSP_SUB_EN
   assign sub_in = SUB_i;
`else
   logic unused_sub;
   assign sub_in     = 1'b0;
   assign unused_sub = SUB_i;
`endif

   assign ctl_in = {valid_i, sub_in, OPMODE_i};

   generate
      if (ABREG == 0) begin : g_ab_comb
         assign a_ab = A_i;
         assign b_ab = B_i;
      end else begin : g_ab_reg
         logic [WIDTH-1:0] a_q [ABREG];
         logic [WIDTH-1:0] b_q [ABREG];
         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               for (int i = 0; i < ABREG; i++) begin
                  a_q[i] <= '0;
                  b_q[i] <= '0;
               end
            end else if (CE_i) begin
               a_q[0] <= A_i;
               b_q[0] <= B_i;
               for (int i = 1; i < ABREG; i++) begin
                  a_q[i] <= a_q[i-1];
                  b_q[i] <= b_q[i-1];
               end
            end
         end
         assign a_ab = a_q[ABREG-1];
         assign b_ab = b_q[ABREG-1];
      end

      if (CTL_D == 0) begin : g_ctl_comb
         assign ctl_p = ctl_in;
      end else begin : g_ctl_reg
         logic [8:0] ctl_q [CTL_D];
         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               for (int i = 0; i < CTL_D; i++) ctl_q[i] <= '0;
            end else if (CE_i) begin
               ctl_q[0] <= ctl_in;
               for (int i = 1; i < CTL_D; i++) ctl_q[i] <= ctl_q[i-1];
            end
         end
         assign ctl_p = ctl_q[CTL_D-1];
      end
   endgenerate

   assign prod = {{WIDTH{1'b0}}, a_ab} * {{WIDTH{1'b0}}, b_ab};

   // A/B ride along with M so the {A,B} concatenation stays aligned with OPMODE
   generate
      if (MREG == 0) begin : g_m_comb
         assign m_p = prod;
         assign a_p = a_ab;
         assign b_p = b_ab;
      end else begin : g_m_reg
         logic [2*WIDTH-1:0] m_q;
         logic [WIDTH-1:0]   a_m, b_m;
         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               m_q <= '0;
               a_m <= '0;
               b_m <= '0;
            end else if (CE_i) begin
               m_q <= prod;
               a_m <= a_ab;
               b_m <= b_ab;
            end
         end
         assign m_p = m_q;
         assign a_p = a_m;
         assign b_p = b_m;
      end

      if (CREG == 0) begin : g_c_comb
         assign c_p = C_i;
      end else begin : g_c_reg
         logic [2*WIDTH-1:0] c_q;
         always_ff @(posedge clock_i) begin
            if (reset_i)                  c_q <= '0;
            else if (CE_i && CREG_en_i)   c_q <= C_i;
         end
         assign c_p = c_q;
      end
   endgenerate

   always_comb begin
      xy = '0;
      case (ctl_p[3:0])
         4'b0101: xy = 48'(m_p);
         4'b1100: xy = 48'(c_p);
         4'b0011: xy = 48'({a_p, b_p});
         default: xy = '0;
      endcase
      z = '0;
      case (ctl_p[6:4])
         3'b010:  z = p_q;
         3'b110:  z = p_q >> WIDTH;
         3'b011:  z = 48'(c_p);
         default: z = '0;
      endcase
      p_d = ctl_p[7] ? (z - xy) : (z + xy);
   end

   // P updates every enabled cycle; idle ops carry OPMODE=0 and clear it
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         p_q     <= '0;
         valid_q <= 1'b0;
      end else if (CE_i) begin
         p_q     <= p_d;
         valid_q <= ctl_p[8];
      end
   end

   assign P_o     = p_q[2*WIDTH-1:0];
   assign carry_o = p_q[2*WIDTH];
   assign valid_o = valid_q;

endmodule
